fetch_stage: RTL

- Instruction-fetch stage that feeds the IF/ID pipeline latch.
- Owns the PC register and drives the instruction-memory request (imemREN/imemaddr, ihit/imemload handshake).
- Presents {instr, pc, npc, valid} to the latch; applies stalls from the hazard unit, branch/jump redirects from EX/MEM, and halt from WB.
- Holds the request address stable across icache misses and resolves redirects that arrive mid-miss.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage_pc_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 98 +++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;
    localparam int WORD_W        = 32;
    localparam int PC_STEP_BYTES = 4;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t PC_STEP = word_t'(PC_STEP_BYTES);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Next-pc source chosen by the fetch FSM each cycle.
    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_PEND  = 2'd3
    } pc_sel_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the instruction-memory handshake, control inputs and IF/ID latch outputs.
interface fetch_stage_if;
    logic                  imemREN;
    fetch_stage_pkg::word_t imemaddr;
    logic                  ihit;
    fetch_stage_pkg::word_t imemload;
    logic                  stall;
    logic                  redirect_en;
    fetch_stage_pkg::word_t redirect_pc;
    logic                  halt;
    logic                  out_valid;
    fetch_stage_pkg::word_t out_instr;
    fetch_stage_pkg::word_t out_pc;
    fetch_stage_pkg::word_t out_npc;
    logic                  halted;

    modport master (
        output imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc, halted,
        input  ihit, imemload, stall, redirect_en, redirect_pc, halt
    );

    modport slave (
        input  imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc, halted,
        output ihit, imemload, stall, redirect_en, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter and pending redirect target, with the next-pc select mux.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic    CLK,
    input  logic    nRST,
    input  pc_sel_t pc_sel_i,
    input  logic    pend_load_i,
    input  word_t   redirect_pc_i,
    output word_t   pc_o,
    output word_t   pending_pc_o
);
    word_t pc_q, pc_d;
    word_t pending_q, pending_d;

    always_comb begin
        pc_d      = pc_q;
        pending_d = pending_q;
        unique case (pc_sel_i)
            PC_HOLD:  pc_d = pc_q;
            PC_INC:   pc_d = pc_q + PC_STEP;
            PC_REDIR: pc_d = redirect_pc_i;
            PC_PEND:  pc_d = pending_q;
            default:  pc_d = pc_q;
        endcase
        if (pend_load_i) begin
            pending_d = redirect_pc_i;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q      <= PC_INIT;
            pending_q <= '0;
        end else begin
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

    assign pc_o         = pc_q;
    assign pending_pc_o = pending_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch FSM, imem request and IF/ID latch outputs.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.master bus
);
    fetch_state_t state_q, state_d;
    pc_sel_t      pc_sel;
    logic         pend_load;
    word_t        pc;
    word_t        pending_pc;

    pc_reg #(.PC_INIT(PC_INIT)) u_pc_reg (
        .CLK           (CLK),
        .nRST          (nRST),
        .pc_sel_i      (pc_sel),
        .pend_load_i   (pend_load),
        .redirect_pc_i (bus.redirect_pc),
        .pc_o          (pc),
        .pending_pc_o  (pending_pc)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (bus.halt) begin
                    state_d = HALT;
                end else if (bus.redirect_en && !bus.ihit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.halt) begin
                    state_d = HALT;
                end else if (bus.ihit) begin
                    state_d = FETCH;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // A miss must complete at the old address, so redirects during a miss are parked in pending_pc.
    always_comb begin
        pc_sel    = PC_HOLD;
        pend_load = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (bus.halt) begin
                    pc_sel = PC_HOLD;
                end else if (bus.redirect_en) begin
                    if (bus.ihit) begin
                        pc_sel = PC_REDIR;
                    end else begin
                        pend_load = 1'b1;
                    end
                end else if (bus.ihit && !bus.stall) begin
                    pc_sel = PC_INC;
                end
            end
            DRAIN: begin
                if (!bus.halt) begin
                    if (bus.ihit) begin
                        pc_sel = bus.redirect_en ? PC_REDIR : PC_PEND;
                    end else if (bus.redirect_en) begin
                        pend_load = 1'b1;
                    end
                end
            end
            default: begin
                pc_sel    = PC_HOLD;
                pend_load = 1'b0;
            end
        endcase
    end

    assign bus.imemREN   = nRST && (state_q != HALT);
    assign bus.out_valid = nRST && (state_q == FETCH) && bus.ihit && !bus.redirect_en && !bus.halt;
    assign bus.imemaddr  = pc;
    assign bus.out_pc    = pc;
    assign bus.out_npc   = pc + PC_STEP;
    assign bus.out_instr = bus.imemload;
    assign bus.halted    = (state_q == HALT);
endmodule
